// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller.
// Holds the D-cache miss FSM state encoding and the default counter width.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2,
    RESUME    = 2'd3
  } miss_state_t;

  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
// Ports: clk_i, rst_i (async high), inc_i (count enable), cnt_o (value).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: load-use hazard, branch flush masking,
// D-cache miss sequencing over req/ack, and saturating perf counters.
// Inputs: ID/EX hazard fields, branch_taken, MEM access/hit/dirty, mem_ack.
// Outputs: Stall/NoOp/PCWrite/Flush/Miss_stall, mem_req/mem_write,
// cache_refill, miss_cnt, miss_cyc.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       IFID_RS1addr_i,
  input  logic [4:0]       IFID_RS2addr_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_RDaddr_i,
  input  logic             branch_taken_i,
  input  logic             EXMEM_MemRead_i,
  input  logic             EXMEM_MemWrite_i,
  input  logic             cache_hit_i,
  input  logic             cache_dirty_i,
  input  logic             mem_ack_i,
  output logic             Stall_o,
  output logic             NoOp_o,
  output logic             PCWrite_o,
  output logic             Flush_o,
  output logic             Miss_stall_o,
  output logic             mem_req_o,
  output logic             mem_write_o,
  output logic             cache_refill_o,
  output logic [CNT_W-1:0] miss_cnt_o,
  output logic [CNT_W-1:0] miss_cyc_o
);

  miss_state_t state_q;
  logic        mem_req_q;
  logic        mem_write_q;
  logic        refill_q;

  logic miss;
  logic idle;
  logic lu;
  logic miss_start;

  assign idle = (state_q == IDLE);
  assign miss = (EXMEM_MemRead_i | EXMEM_MemWrite_i) & ~cache_hit_i;
  assign miss_start = idle & miss;

  // Combinational so the pipeline freezes on the edge the miss is seen.
  assign Miss_stall_o = miss_start | ~idle;

  assign lu = IDEX_MemRead_i
            & (IDEX_RDaddr_i != 5'd0)
            & ((IDEX_RDaddr_i == IFID_RS1addr_i)
             | (IDEX_RDaddr_i == IFID_RS2addr_i));

  // A miss outranks the bubble; lu is re-evaluated once released.
  assign Stall_o   = lu & ~Miss_stall_o;
  assign NoOp_o    = Stall_o;
  assign Flush_o   = branch_taken_i & ~Stall_o & ~Miss_stall_o;
  assign PCWrite_o = ~lu & ~Miss_stall_o;

  // Outputs are registered from the next state, so they stay pure
  // decodes of state_q while being flop outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_write_q <= 1'b0;
      refill_q    <= 1'b0;
    end else begin
      mem_req_q   <= 1'b0;
      mem_write_q <= 1'b0;
      refill_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (miss) begin
            mem_req_q <= 1'b1;
            if (cache_dirty_i) begin
              state_q     <= WRITEBACK;
              mem_write_q <= 1'b1;
            end else begin
              state_q <= REFILL;
            end
          end
        end
        WRITEBACK: begin
          mem_req_q <= 1'b1;
          if (mem_ack_i) begin
            state_q <= REFILL;
          end else begin
            mem_write_q <= 1'b1;
          end
        end
        REFILL: begin
          if (mem_ack_i) begin
            state_q  <= RESUME;
            refill_q <= 1'b1;
          end else begin
            mem_req_q <= 1'b1;
          end
        end
        RESUME: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_req_o      = mem_req_q;
  assign mem_write_o    = mem_write_q;
  assign cache_refill_o = refill_q;

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (miss_start),
    .cnt_o (miss_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_miss_cyc (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (Miss_stall_o),
    .cnt_o (miss_cyc_o)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (16-bit and 2-bit counter instances).
// Inputs change at posedge+1, outputs are sampled at the falling edge.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1, rs2, idex_rd;
  logic       idex_mr, br, ex_rd, ex_wr, hit, dirty, ack;

  logic        st, nop, pcw, fl, ms, req, wr, rf;
  logic [15:0] mcnt, mcyc;
  logic        st2, nop2, pcw2, fl2, ms2, req2, wr2, rf2;
  logic [1:0]  mcnt2, mcyc2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .IFID_RS1addr_i(rs1), .IFID_RS2addr_i(rs2),
    .IDEX_MemRead_i(idex_mr), .IDEX_RDaddr_i(idex_rd),
    .branch_taken_i(br),
    .EXMEM_MemRead_i(ex_rd), .EXMEM_MemWrite_i(ex_wr),
    .cache_hit_i(hit), .cache_dirty_i(dirty), .mem_ack_i(ack),
    .Stall_o(st), .NoOp_o(nop), .PCWrite_o(pcw), .Flush_o(fl),
    .Miss_stall_o(ms), .mem_req_o(req), .mem_write_o(wr),
    .cache_refill_o(rf), .miss_cnt_o(mcnt), .miss_cyc_o(mcyc)
  );

  pipe_hazard_ctrl #(.CNT_W(2)) dut_s (
    .clk_i(clk), .rst_i(rst),
    .IFID_RS1addr_i(rs1), .IFID_RS2addr_i(rs2),
    .IDEX_MemRead_i(idex_mr), .IDEX_RDaddr_i(idex_rd),
    .branch_taken_i(br),
    .EXMEM_MemRead_i(ex_rd), .EXMEM_MemWrite_i(ex_wr),
    .cache_hit_i(hit), .cache_dirty_i(dirty), .mem_ack_i(ack),
    .Stall_o(st2), .NoOp_o(nop2), .PCWrite_o(pcw2), .Flush_o(fl2),
    .Miss_stall_o(ms2), .mem_req_o(req2), .mem_write_o(wr2),
    .cache_refill_o(rf2), .miss_cnt_o(mcnt2), .miss_cyc_o(mcyc2)
  );

  task automatic quiet();
    rs1 = 5'd0; rs2 = 5'd0; idex_rd = 5'd0; idex_mr = 1'b0;
    br = 1'b0; ex_rd = 1'b0; ex_wr = 1'b0;
    hit = 1'b1; dirty = 1'b0; ack = 1'b0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    quiet();
    rst = 1'b0;
    #2 rst = 1'b1;
    nxt();
    #1;
    checks++;
    if ({req, wr, rf, ms, st, pcw} !== 6'b000001) begin
      errors++;
      $display("FAIL reset_ctl got %b exp 000001", {req, wr, rf, ms, st, pcw});
    end
    checks++;
    if (mcnt !== 16'd0 || mcyc !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnt got %0d/%0d exp 0/0", mcnt, mcyc);
    end
    nxt();
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    int v_rs1 [5] = '{5, 0, 3, 7, 3};
    int v_rs2 [5] = '{0, 0, 7, 7, 4};
    int v_rd  [5] = '{5, 0, 7, 7, 9};
    logic [4:0] v_mr = 5'b10111;
    logic [4:0] v_br = 5'b01100;
    // expected {Stall, NoOp, PCWrite, Flush, Miss_stall}
    logic [4:0] v_exp [5] = '{5'b11000, 5'b00100, 5'b11000,
                              5'b00110, 5'b00100};
    quiet();
    for (int i = 0; i < 5; i++) begin
      rs1 = 5'(v_rs1[i]);
      rs2 = 5'(v_rs2[i]);
      idex_rd = 5'(v_rd[i]);
      idex_mr = v_mr[i];
      br = v_br[i];
      #1;
      checks++;
      if ({st, nop, pcw, fl, ms} !== v_exp[i]) begin
        errors++;
        $display("FAIL load_use[%0d] got %b exp %b",
                 i, {st, nop, pcw, fl, ms}, v_exp[i]);
      end
    end
    quiet();
    nxt();
  endtask

  task automatic test_clean_miss();
    logic [5:0] e_ms  = 6'b011111;
    logic [5:0] e_req = 6'b001110;
    logic [5:0] e_rf  = 6'b010000;
    do_reset();
    ex_rd = 1'b1; hit = 1'b0; dirty = 1'b0;
    for (int c = 0; c < 6; c++) begin
      ack = (c == 3);
      if (c >= 4) hit = 1'b1;
      #4;
      checks++;
      if ({ms, req, wr, rf} !== {e_ms[c], e_req[c], 1'b0, e_rf[c]}) begin
        errors++;
        $display("FAIL clean_miss[%0d] got %b exp %b", c,
                 {ms, req, wr, rf}, {e_ms[c], e_req[c], 1'b0, e_rf[c]});
      end
      nxt();
    end
    #4;
    checks++;
    if (mcnt !== 16'd1 || mcyc !== 16'd5) begin
      errors++;
      $display("FAIL clean_cnt got %0d/%0d exp 1/5", mcnt, mcyc);
    end
    quiet();
    nxt();
  endtask

  task automatic test_dirty_miss();
    logic [5:0] e_ms  = 6'b011111;
    logic [5:0] e_req = 6'b001110;
    logic [5:0] e_wr  = 6'b000110;
    logic [5:0] e_rf  = 6'b010000;
    do_reset();
    ex_wr = 1'b1; hit = 1'b0; dirty = 1'b1;
    for (int c = 0; c < 6; c++) begin
      ack = (c == 2) || (c == 3);
      if (c >= 4) hit = 1'b1;
      #4;
      checks++;
      if ({ms, req, wr, rf} !== {e_ms[c], e_req[c], e_wr[c], e_rf[c]}) begin
        errors++;
        $display("FAIL dirty_miss[%0d] got %b exp %b", c,
                 {ms, req, wr, rf}, {e_ms[c], e_req[c], e_wr[c], e_rf[c]});
      end
      nxt();
    end
    #4;
    checks++;
    if (mcnt !== 16'd1 || mcyc !== 16'd5) begin
      errors++;
      $display("FAIL dirty_cnt got %0d/%0d exp 1/5", mcnt, mcyc);
    end
    quiet();
    nxt();
  endtask

  task automatic test_priority();
    // expected {Miss_stall, Stall, PCWrite, Flush} per cycle
    logic [3:0] e [5] = '{4'b1000, 4'b1000, 4'b1000, 4'b0100, 4'b0011};
    do_reset();
    ex_rd = 1'b1; hit = 1'b0;
    idex_mr = 1'b1; idex_rd = 5'd5; rs1 = 5'd5; br = 1'b1;
    for (int c = 0; c < 5; c++) begin
      ack = (c == 1);
      if (c >= 2) hit = 1'b1;
      if (c == 4) idex_mr = 1'b0;
      #4;
      checks++;
      if ({ms, st, pcw, fl} !== e[c]) begin
        errors++;
        $display("FAIL priority[%0d] got %b exp %b", c,
                 {ms, st, pcw, fl}, e[c]);
      end
      nxt();
    end
    quiet();
    nxt();
  endtask

  task automatic test_reset_refill();
    do_reset();
    ex_rd = 1'b1; hit = 1'b0;
    nxt();
    #4;
    checks++;
    if ({req, ms, mcnt} !== {1'b1, 1'b1, 16'd1}) begin
      errors++;
      $display("FAIL pre_rst got req=%b ms=%b cnt=%0d exp 1 1 1",
               req, ms, mcnt);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({req, ms} !== 2'b01) begin
      errors++;
      $display("FAIL rst_refill got req=%b ms=%b exp 0 1", req, ms);
    end
    checks++;
    if (mcnt !== 16'd0 || mcyc !== 16'd0) begin
      errors++;
      $display("FAIL rst_cnt got %0d/%0d exp 0/0", mcnt, mcyc);
    end
    hit = 1'b1;
    #1;
    checks++;
    if (ms !== 1'b0) begin
      errors++;
      $display("FAIL rst_ms_hit got %b exp 0", ms);
    end
    nxt();
    rst = 1'b0;
    quiet();
    nxt();
  endtask

  task automatic test_back_to_back();
    do_reset();
    ex_rd = 1'b1; hit = 1'b0;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 3; c++) begin
        ack = (c == 1);
        #4;
        checks++;
        if ({ms, rf} !== {1'b1, (c == 2)}) begin
          errors++;
          $display("FAIL b2b[%0d.%0d] got %b exp %b", k, c,
                   {ms, rf}, {1'b1, (c == 2)});
        end
        nxt();
      end
    end
    hit = 1'b1; ack = 1'b0;
    #4;
    checks++;
    if ({mcnt, mcyc, ms} !== {16'd5, 16'd15, 1'b0}) begin
      errors++;
      $display("FAIL b2b_cnt16 got %0d/%0d ms=%b exp 5/15 0",
               mcnt, mcyc, ms);
    end
    checks++;
    if ({mcnt2, mcyc2} !== 4'b1111) begin
      errors++;
      $display("FAIL sat_cnt2 got %0d/%0d exp 3/3", mcnt2, mcyc2);
    end
    nxt();
  endtask

  task automatic test_stray_ack();
    do_reset();
    ack = 1'b1;
    #4;
    checks++;
    if ({ms, req} !== 2'b00) begin
      errors++;
      $display("FAIL stray_ack got %b exp 00", {ms, req});
    end
    nxt();
    ack = 1'b0;
    #4;
    checks++;
    if ({ms, req, wr, rf, mcnt} !== {4'b0000, 16'd0}) begin
      errors++;
      $display("FAIL stray_after got %b cnt=%0d exp 0000 0",
               {ms, req, wr, rf}, mcnt);
    end
    nxt();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_clean_miss();
    test_dirty_miss();
    test_priority();
    test_reset_refill();
    test_back_to_back();
    test_stray_ack();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage pipeline. It generates the `Stall`, `Flush` and `Miss_stall` controls consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards, masks branch flushes, and runs the data-cache miss sequence (dirty write-back, refill, re-lookup) over a req/ack memory handshake. It also keeps saturating performance counters.

## Interface
- `CNT_W`, 16, width of the performance counters.

- `clk_i`  in  1  pipeline clock; all state updates on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `IFID_RS1addr_i`  in  5  rs1 of the instruction in ID.
- `IFID_RS2addr_i`  in  5  rs2 of the instruction in ID.
- `IDEX_MemRead_i`  in  1  the instruction in EX is a load.
- `IDEX_RDaddr_i`  in  5  rd of the instruction in EX.
- `branch_taken_i`  in  1  branch resolved taken in ID.
- `EXMEM_MemRead_i`  in  1  load in MEM.
- `EXMEM_MemWrite_i`  in  1  store in MEM.
- `cache_hit_i`  in  1  D-cache tag hit for the current MEM access.
- `cache_dirty_i`  in  1  victim line is dirty.
- `mem_ack_i`  in  1  one-cycle memory completion pulse.
- `Stall_o`  out  1  load-use stall to IF/ID.
- `NoOp_o`  out  1  bubble insert into ID/EX (zeroes control bits).
- `PCWrite_o`  out  1  PC update enable.
- `Flush_o`  out  1  IF/ID flush.
- `Miss_stall_o`  out  1  hold to all four pipeline registers.
- `mem_req_o`  out  1  memory request.
- `mem_write_o`  out  1  1 = write-back, 0 = refill read.
- `cache_refill_o`  out  1  write the returned line into the D-cache.
- `miss_cnt_o`  out  `CNT_W`  number of D-cache misses.
- `miss_cyc_o`  out  `CNT_W`  number of cycles with `Miss_stall_o` = 1.

## Operation
- **Miss detection:** `miss` = (`EXMEM_MemRead_i` | `EXMEM_MemWrite_i`) & ~`cache_hit_i`. It is only evaluated in IDLE.
- **FSM states:** IDLE, WRITEBACK, REFILL, RESUME.
  - IDLE: on `miss` & `cache_dirty_i`, go to WRITEBACK. On `miss` & ~`cache_dirty_i`, go to REFILL. Otherwise stay in IDLE.
  - WRITEBACK: on `mem_ack_i`, go to REFILL. Otherwise stay.
  - REFILL: on `mem_ack_i`, go to RESUME. Otherwise stay.
  - RESUME: go to IDLE unconditionally. This is the re-lookup cycle, in which the cache is written.
- **Memory outputs** are Moore, decoded from the state register only:
  - `mem_req_o` = 1 in WRITEBACK or REFILL.
  - `mem_write_o` = 1 in WRITEBACK.
  - `cache_refill_o` = 1 in RESUME.
- **`Miss_stall_o`** = (IDLE & `miss`) | WRITEBACK | REFILL | RESUME. It is combinational, so the pipeline holds at the same edge the miss is seen.
- **Load-use stall:** `lu` = `IDEX_MemRead_i` & (`IDEX_RDaddr_i` != 0) & (`IDEX_RDaddr_i` == `IFID_RS1addr_i` | `IDEX_RDaddr_i` == `IFID_RS2addr_i`).
  - `Stall_o` = `lu` & ~`Miss_stall_o`.
  - `NoOp_o` = `Stall_o`.
- **Flush:** `Flush_o` = `branch_taken_i` & ~`Stall_o` & ~`Miss_stall_o`. The held branch re-asserts after the stall releases.
- **PC enable:** `PCWrite_o` = ~`lu` & ~`Miss_stall_o`.
- **Counters:** both saturate at all-ones and never wrap.
  - `miss_cnt_o` increments on the IDLE→WRITEBACK and IDLE→REFILL transitions.
  - `miss_cyc_o` increments on every edge where `Miss_stall_o` = 1.
- **Handshake:**
  - `mem_ack_i` is sampled only in WRITEBACK and REFILL; an ack in IDLE or RESUME is ignored.
  - `mem_req_o` drops the cycle after the ack of the refill.
  - `mem_req_o` stays high across the WRITEBACK→REFILL transition, with `mem_write_o` changing 1→0.

## Timing
- **Reset values:** state = IDLE. `mem_req_o`, `mem_write_o` and `cache_refill_o` = 0. Both counters = 0.
- **Reset mid-operation:** `rst_i` forces these values immediately, asynchronously. `mem_req_o` drops in the same cycle, and any in-flight transfer is abandoned.
- **Clean-miss penalty:** 2 + R stall cycles, where R is the number of cycles spent in REFILL (R ≥ 1).
- **Dirty-miss penalty:** 2 + W + R stall cycles, where W is the number of cycles spent in WRITEBACK.
- **Ack timing:** an ack in the first cycle of WRITEBACK or REFILL is legal and gives W or R = 1.
- **Load-use:** 1 bubble, fully combinational with no latency.
- **Simultaneous miss and load-use:** the miss wins. `Stall_o` = 0 while `Miss_stall_o` = 1, and `lu` is re-evaluated after release.
- **Back-to-back misses:** a miss present in the IDLE cycle right after RESUME starts a new sequence without any gap cycle.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - the state enum `miss_state_t` (IDLE=0, WRITEBACK=1, REFILL=2, RESUME=3);
  - the default `CNT_W`.
- Sub-module `sat_counter` (parameter `W`; ports `clk_i`, `rst_i`, `inc_i`, `cnt_o`), instantiated twice for the two counters.
- Hazard and flush logic stays combinational in the top level; the FSM is a single always block.

## Test plan
1. **Load-use:** `IDEX_MemRead_i`=1, `IDEX_RDaddr_i`=5, `IFID_RS1addr_i`=5 → `Stall_o`=`NoOp_o`=1, `PCWrite_o`=0. With rd=0 → all stall outputs 0.
2. **Clean miss:** `EXMEM_MemRead_i`=1, hit=0, dirty=0, ack 3 cycles after REFILL entry → states REFILL×3, then RESUME. `Miss_stall_o`=1 for 5 cycles, `cache_refill_o`=1 for 1 cycle, `miss_cnt_o`=1, `miss_cyc_o`=5.
3. **Dirty miss:** store, hit=0, dirty=1, acks after 2 cycles (WB) and 1 cycle (REFILL) → `mem_write_o` 1,1 then 0. `mem_req_o` continuous for 3 cycles. `Miss_stall_o`=1 for 5 cycles.
4. **Priority:** miss together with load-use and `branch_taken_i` → only `Miss_stall_o`=1. After release, `Stall_o`=1 for one cycle, then `Flush_o`=1.
5. **Reset in REFILL:** assert `rst_i` mid-cycle → `mem_req_o`=0 and `Miss_stall_o` follows miss/IDLE before the next edge. Counters = 0.
6. **Saturation and stray ack:** with `CNT_W`=2, 5 misses → `miss_cnt_o`=3. A stray `mem_ack_i` in IDLE → no state change.
